pack_uart_tx: RTL and testbench



---
 rtl/pack_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_pack_uart_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_uart_tx.sv
// pack_uart_tx: latches one pattern-generator command on i_start and
// serializes it byte by byte through a UART tx start/done handshake.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_start            one-cycle request to send a packet
//   i_output_pattern   output pattern word (sent LS byte first)
//   i_freq_pattern     frequency select word (sent LS byte first)
//   i_ctrl             control byte
//   i_high_period      high-frequency period byte
//   i_low_period       low-frequency period byte
//   o_tx_start         one-cycle start pulse to the UART tx
//   o_tx_data          byte to transmit, stable until its done tick
//   i_tx_done_tick     UART tx byte-complete pulse
//   o_busy             packet in progress
//   o_done_tick        one-cycle pulse after the last byte completes
//
// Build option: define PACK_CHECKSUM_EN to append an XOR checksum byte.

module pack_uart_tx #(
    parameter int DATA_BIT     = 32,
    parameter int PACK_NUM     = (DATA_BIT / 8) * 2 + 3,
    parameter int BYTE_GAP_CLK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic [7:0]          i_ctrl,
    input  logic [7:0]          i_high_period,
    input  logic [7:0]          i_low_period,
    output logic                o_tx_start,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_done_tick,
    output logic                o_busy,
    output logic                o_done_tick
);

    localparam int SW = PACK_NUM * 8;

`ifdef PACK_CHECKSUM_EN
    localparam int NBYTES = PACK_NUM + 1;
`else
    localparam int NBYTES = PACK_NUM;
`endif

    localparam int            CW       = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
    // GAP holds BYTE_GAP_CLK+1 cycles, so the next start lands
    // BYTE_GAP_CLK+2 cycles after the accepted done tick.
    localparam logic [7:0]    GAP_LOAD = 8'(BYTE_GAP_CLK);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        GAP,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    gap_q, gap_d;

`ifdef PACK_CHECKSUM_EN
    localparam logic [CW-1:0] CHK_IDX = CW'(PACK_NUM);

    logic [7:0] chk_q, chk_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
`ifdef PACK_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
`ifdef PACK_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
`ifdef PACK_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    // Low byte of the register goes out first.
                    shreg_d = SW'({i_low_period, i_high_period, i_ctrl,
                                   i_freq_pattern, i_output_pattern});
                    cnt_d   = '0;
`ifdef PACK_CHECKSUM_EN
                    chk_d   = '0;
`endif
                    state_d = SEND;
                end
            end
            SEND: begin
`ifdef PACK_CHECKSUM_EN
                // Fold each data byte in as it is launched.
                if (cnt_q != CHK_IDX) begin
                    chk_d = chk_q ^ shreg_q[7:0];
                end
`endif
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_tx_done_tick) begin
                    shreg_d = shreg_q >> 8;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else if (BYTE_GAP_CLK == 0) begin
                        state_d = SEND;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_tx_start  = (state_q == SEND);
    assign o_done_tick = (state_q == DONE);
    assign o_busy      = (state_q == SEND) || (state_q == WAIT_DONE) ||
                         (state_q == GAP);

`ifdef PACK_CHECKSUM_EN
    assign o_tx_data = (cnt_q == CHK_IDX) ? chk_q : shreg_q[7:0];
`else
    assign o_tx_data = shreg_q[7:0];
`endif

endmodule

// File: tb/tb_pack_uart_tx.sv
// tb_pack_uart_tx: randomized packet checks of pack_uart_tx against a
// byte-list reference model, with a gap-0 and a gap-4 instance.
`timescale 1ns/1ps

module tb_pack_uart_tx;

    localparam int DB = 32;
    localparam int PN = 11;
`ifdef PACK_CHECKSUM_EN
    localparam int NB = PN + 1;
`else
    localparam int NB = PN;
`endif
    localparam int TX_LAT = 10;

    typedef logic [7:0] bq_t[$];

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        st    = 1'b0;
    logic        sel   = 1'b0;
    logic        spur  = 1'b0;
    logic        txd   = 1'b0;
    logic [31:0] op    = '0;
    logic [31:0] fp    = '0;
    logic [7:0]  ct    = '0;
    logic [7:0]  hp    = '0;
    logic [7:0]  lp    = '0;

    logic       s0, b0, d0, s4, b4, d4;
    logic [7:0] x0, x4;
    logic       m_start, m_busy, m_done;
    logic [7:0] m_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int cd    = 0;

    logic [7:0] bq[$];
    int         sq[$];
    int         dq[$];
    int         eq[$];

    pack_uart_tx #(.DATA_BIT(DB), .BYTE_GAP_CLK(0)) u_dut0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (st && !sel),
        .i_output_pattern(op),
        .i_freq_pattern  (fp),
        .i_ctrl          (ct),
        .i_high_period   (hp),
        .i_low_period    (lp),
        .o_tx_start      (s0),
        .o_tx_data       (x0),
        .i_tx_done_tick  (txd && !sel),
        .o_busy          (b0),
        .o_done_tick     (d0)
    );

    pack_uart_tx #(.DATA_BIT(DB), .BYTE_GAP_CLK(4)) u_dut4 (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (st && sel),
        .i_output_pattern(op),
        .i_freq_pattern  (fp),
        .i_ctrl          (ct),
        .i_high_period   (hp),
        .i_low_period    (lp),
        .o_tx_start      (s4),
        .o_tx_data       (x4),
        .i_tx_done_tick  (txd && sel),
        .o_busy          (b4),
        .o_done_tick     (d4)
    );

    assign m_start = sel ? s4 : s0;
    assign m_busy  = sel ? b4 : b0;
    assign m_done  = sel ? d4 : d0;
    assign m_data  = sel ? x4 : x0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART tx model: done TX_LAT cycles after each start, plus optional
    // spurious ticks in the start cycle and two cycles into a gap.
    always @(negedge clk) begin
        txd = 1'b0;
        if (!rst_n) begin
            cd = 0;
        end else if (m_start) begin
            bq.push_back(m_data);
            sq.push_back(cyc);
            cd = TX_LAT;
            if (spur) txd = 1'b1;
        end else if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                txd = 1'b1;
                dq.push_back(cyc);
            end
        end else if (spur && dq.size() > 0 && cyc == dq[$] + 2) begin
            txd = 1'b1;
        end
        if (rst_n && m_done) eq.push_back(cyc);
    end

    function automatic bq_t model(input logic [31:0] o, input logic [31:0] f,
                                  input logic [7:0] c, input logic [7:0] h,
                                  input logic [7:0] l);
        bq_t q;
        logic [7:0] x;
        for (int i = 0; i < DB / 8; i++) q.push_back(o[8*i +: 8]);
        for (int i = 0; i < DB / 8; i++) q.push_back(f[8*i +: 8]);
        q.push_back(c);
        q.push_back(h);
        q.push_back(l);
`ifdef PACK_CHECKSUM_EN
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        q.push_back(x);
`else
        x = 8'h00;
`endif
        return q;
    endfunction

    task automatic clr();
        bq.delete();
        sq.delete();
        dq.delete();
        eq.delete();
    endtask

    task automatic pulse_start(input logic s, input logic [31:0] o,
                               input logic [31:0] f, input logic [7:0] c,
                               input logic [7:0] h, input logic [7:0] l,
                               output int t0);
        @(negedge clk);
        sel = s;
        op  = o;
        fp  = f;
        ct  = c;
        hp  = h;
        lp  = l;
        st  = 1'b1;
        t0  = cyc;
        @(negedge clk);
        st = 1'b0;
        op = $urandom;
        fp = $urandom;
        ct = 8'($urandom);
        hp = 8'($urandom);
        lp = 8'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (eq.size() == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({s0, b0, d0, x0} !== 11'd0) begin
            fails++;
            $display("FAIL reset_dut0: got %b, want 0", {s0, b0, d0, x0});
        end
        tests++;
        if ({s4, b4, d4, x4} !== 11'd0) begin
            fails++;
            $display("FAIL reset_dut4: got %b, want 0", {s4, b4, d4, x4});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({s0, b0, d0, x0, s4, b4, d4, x4} !== 22'd0) begin
            fails++;
            $display("FAIL idle_after_reset: got %b, want 0",
                     {s0, b0, d0, x0, s4, b4, d4, x4});
        end
    endtask

    task automatic test_packet(input logic s, input logic [31:0] o,
                               input logic [31:0] f, input logic [7:0] c,
                               input logic [7:0] h, input logic [7:0] l,
                               input string nm);
        bq_t ex;
        int  t0, n, lat;
        ex  = model(o, f, c, h, l);
        lat = s ? 6 : 1;
        clr();
        pulse_start(s, o, f, c, h, l, t0);
        tests++;
        if (m_busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_rise: got %b, want 1", nm, m_busy);
        end
        wait_done(n);
        tests++;
        if (eq.size() == 0) begin
            fails++;
            $display("FAIL %s timeout: no done tick in %0d cycles", nm, n);
        end
        tests++;
        if (bq.size() != NB) begin
            fails++;
            $display("FAIL %s byte_count: got %0d, want %0d", nm, bq.size(), NB);
        end
        for (int i = 0; i < NB; i++) begin
            tests++;
            if (i >= bq.size()) begin
                fails++;
                $display("FAIL %s byte%0d: missing, want %h", nm, i, ex[i]);
            end else if (bq[i] !== ex[i]) begin
                fails++;
                $display("FAIL %s byte%0d: got %h, want %h", nm, i, bq[i], ex[i]);
            end
        end
        tests++;
        if (sq.size() == 0 || sq[0] != t0 + 1) begin
            fails++;
            $display("FAIL %s first_start: got %0d, want %0d", nm,
                     (sq.size() > 0) ? sq[0] : -1, t0 + 1);
        end
        for (int i = 0; i + 1 < sq.size() && i < dq.size(); i++) begin
            tests++;
            if (sq[i+1] - dq[i] != lat) begin
                fails++;
                $display("FAIL %s gap%0d: got %0d, want %0d", nm, i,
                         sq[i+1] - dq[i], lat);
            end
        end
        tests++;
        if (eq.size() != 1) begin
            fails++;
            $display("FAIL %s done_ticks: got %0d, want 1", nm, eq.size());
        end
        tests++;
        if (eq.size() == 0 || dq.size() == 0 || eq[0] != dq[$] + 1) begin
            fails++;
            $display("FAIL %s done_after_last: got %0d, want %0d", nm,
                     (eq.size() > 0) ? eq[0] : -1,
                     (dq.size() > 0) ? dq[$] + 1 : -1);
        end
        tests++;
        if (m_busy !== 1'b0) begin
            fails++;
            $display("FAIL %s busy_fall: got %b, want 0", nm, m_busy);
        end
    endtask

    task automatic test_busy();
        bq_t ex;
        int  t0, n;
        logic [31:0] o, f;
        o  = $urandom;
        f  = $urandom;
        ex = model(o, f, 8'h3C, 8'h07, 8'h99);
        clr();
        pulse_start(1'b1, o, f, 8'h3C, 8'h07, 8'h99, t0);
        n = 0;
        while (bq.size() < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        op = 32'hFFFF_FFFF;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        wait_done(n);
        repeat (200) @(negedge clk);
        tests++;
        if (bq.size() != NB || eq.size() != 1) begin
            fails++;
            $display("FAIL busy_reject_count: got %0d bytes %0d dones, want %0d and 1",
                     bq.size(), eq.size(), NB);
        end
        for (int i = 0; i < NB && i < bq.size(); i++) begin
            tests++;
            if (bq[i] !== ex[i]) begin
                fails++;
                $display("FAIL busy_reject_byte%0d: got %h, want %h", i, bq[i], ex[i]);
            end
        end
    endtask

    task automatic test_spurious();
        spur = 1'b1;
        test_packet(1'b1, $urandom, $urandom, 8'($urandom), 8'($urandom),
                    8'($urandom), "spurious");
        spur = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t0, n;
        clr();
        pulse_start(1'b1, $urandom, $urandom, 8'h11, 8'h22, 8'h33, t0);
        n = 0;
        while (bq.size() < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bq.size() < 5) begin
            fails++;
            $display("FAIL reset_mid_reach: got %0d bytes, want 5", bq.size());
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({s4, b4, d4, x4} !== 11'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %b, want 0", {s4, b4, d4, x4});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_packet(1'b1, $urandom, $urandom, 8'($urandom), 8'($urandom),
                    8'($urandom), "after_reset");
    endtask

    initial begin
        test_reset();
        test_packet(1'b0, 32'h1234_5678, 32'hA5A5_0F0F, 8'h01, 8'd5, 8'd20,
                    "basic");
        test_packet(1'b1, $urandom, $urandom, 8'($urandom), 8'($urandom),
                    8'($urandom), "gap");
        test_busy();
        test_spurious();
        test_reset_mid();
        for (int k = 0; k < 4; k++) begin
            test_packet(1'(k), $urandom, $urandom, 8'($urandom), 8'($urandom),
                        8'($urandom), "random");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
